// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Signed operations run on magnitudes. The result signs are latched at start
// and applied in FINISH. Multiply uses right-shift shift-add. Divide uses
// restoring division. Both take 32 iterations.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             MultStart,
  input  logic             DivStart,
  input  logic             IsSigned,
  input  logic             MtHi,
  input  logic             MtLo,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FINISH} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;    // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d;  // |A| for multiply, |B| for divide
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, divzero_q, divzero_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mult_sum;
  logic [2*WIDTH-1:0] mult_next;
  logic [WIDTH:0]     rem_sh, div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign mag_a = (IsSigned && A[WIDTH-1]) ? -A : A;
  assign mag_b = (IsSigned && B[WIDTH-1]) ? -B : B;

  // One shift-add step: add the multiplicand when the low bit is set, then shift right.
  assign mult_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mult_next = {mult_sum, acc_q[WIDTH-1:1]};

  // One restoring step. Shift in the next dividend bit, then do a trial subtract.
  // The remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, opnd_q};
  assign div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // State register and datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  // Next-state logic, operand capture, iteration and result write-back
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (MultStart || DivStart) begin
          neg_res_d = IsSigned & (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_rem_d = IsSigned & A[WIDTH-1];
          cnt_d     = '0;
          if (MultStart) begin
            opnd_d   = mag_a;
            acc_d    = {{WIDTH{1'b0}}, mag_b};
            is_div_d = 1'b0;
            dz_d     = 1'b0;
            state_d  = S_MULT;
          end else begin
            opnd_d   = mag_b;
            acc_d    = {{WIDTH{1'b0}}, mag_a};
            is_div_d = 1'b1;
            dz_d     = (B == '0);
            state_d  = (B == '0) ? S_FINISH : S_DIV;
          end
        end else begin
          if (MtHi) hi_d = A;
          if (MtLo) lo_d = A;
        end
      end
      S_MULT: begin
        acc_d = mult_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_FINISH;
        end
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        // Divide-by-zero waits one extra edge here.
        // This makes its Done arrive two cycles after the start.
        if (dz_q && cnt_q == '0) begin
          cnt_d = {{(CW-1){1'b0}}, 1'b1};
        end else begin
          cnt_d   = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (dz_q) begin
            divzero_d = 1'b1;
          end else if (is_div_q) begin
            lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end else begin
            {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = divzero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit. Each started operation pushes its expected
// HI/LO/DivZero. A negedge monitor pops the entry on every Done pulse.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset, MultStart, DivStart, IsSigned, MtHi, MtLo;
  logic [W-1:0] A, B, Hi, Lo;
  logic         Busy, Done, DivZero;

  always #5 Clk = ~Clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .MultStart(MultStart), .DivStart(DivStart),
    .IsSigned(IsSigned), .MtHi(MtHi), .MtLo(MtLo), .A(A), .B(B),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .DivZero(DivZero)
  );

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           done_seen = 0;
  int           ops_pushed = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Result monitor: pop one expectation per Done pulse
  always @(negedge Clk) begin
    if (Done === 1'b1) begin
      exp_t e;
      done_seen++;
      check_eq("done_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("res_hi", Hi, e.hi);
        check_eq("res_lo", Lo, e.lo);
        check_eq("res_dz", DivZero, e.dz);
        $display("done #%0d: hi=%h lo=%h dz=%b (exp %h %h %b)", done_seen, Hi, Lo, DivZero, e.hi, e.lo, e.dz);
      end
    end
  end

  // Start one operation and push its expectation. Scramble A/B after the start edge.
  // Then wait (bounded) for Done and check latency and Busy duration.
  // ignore_at >= 0 injects a start/mt pulse while the unit is busy.
  task automatic run_op(input logic do_mult, input logic do_div, input logic sgn,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input string name, input int ignore_at);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb_v, q, r;
    int          lat, busy_cnt, exp_lat;
    sa   = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb_v = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    e.dz = 1'b0;
    if (do_mult) begin
      p = 64'(sa * sb_v);
      e.hi = p[63:32];
      e.lo = p[31:0];
      exp_lat = 33;
    end else if (b == '0) begin
      e.hi = m_hi;
      e.lo = m_lo;
      e.dz = 1'b1;
      exp_lat = 2;
    end else begin
      q = sa / sb_v;
      r = sa % sb_v;
      e.hi = r[31:0];
      e.lo = q[31:0];
      exp_lat = 33;
    end
    m_hi = e.hi;
    m_lo = e.lo;
    sb.push_back(e);
    ops_pushed++;
    $display("start %s: mult=%b div=%b signed=%b a=%h b=%h", name, do_mult, do_div, sgn, a, b);

    MultStart = do_mult; DivStart = do_div; IsSigned = sgn; A = a; B = b;
    @(posedge Clk); #1;
    MultStart = 1'b0; DivStart = 1'b0;
    A = $urandom; B = $urandom; IsSigned = 1'($urandom);

    lat = -1;
    busy_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge Clk);
      if (k == ignore_at) begin
        MultStart = 1'b1; DivStart = 1'b1; MtHi = 1'b1; MtLo = 1'b1; A = $urandom; B = 0;
      end else if (k == ignore_at + 1) begin
        MultStart = 1'b0; DivStart = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
      end
      if (Done === 1'b1) begin
        lat = k;
        break;
      end
      if (Busy === 1'b1) busy_cnt++;
    end
    check_eq({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check_eq({name, "_busy_in_done"}, Busy, 0);
  endtask

  task automatic mt(input logic hi, input logic lo, input logic [W-1:0] a);
    MtHi = hi; MtLo = lo; A = a;
    @(posedge Clk); #1;
    MtHi = 1'b0; MtLo = 1'b0;
    if (hi) m_hi = a;
    if (lo) m_lo = a;
    $display("mt hi=%b lo=%b a=%h", hi, lo, a);
    check_eq("mt_hi", Hi, m_hi);
    check_eq("mt_lo", Lo, m_lo);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rm, rs;
    Reset = 1'b1; MultStart = 1'b0; DivStart = 1'b0; IsSigned = 1'b0;
    MtHi = 1'b0; MtLo = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check_eq("rst_hi", Hi, 0);
    check_eq("rst_lo", Lo, 0);
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_done", Done, 0);
    check_eq("rst_dz", DivZero, 0);

    run_op(1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", -1);
    check_eq("tp_multu_hi", Hi, 32'hFFFFFFFE);
    check_eq("tp_multu_lo", Lo, 32'h00000001);
    run_op(1, 0, 1, 32'hFFFFFFFD, 32'd7, "mult_neg", -1);
    check_eq("tp_mult_hi", Hi, 32'hFFFFFFFF);
    check_eq("tp_mult_lo", Lo, 32'hFFFFFFEB);
    run_op(0, 1, 1, 32'hFFFFFFF9, 32'd2, "div_neg", -1);
    check_eq("tp_div_lo", Lo, 32'hFFFFFFFD);
    check_eq("tp_div_hi", Hi, 32'hFFFFFFFF);
    run_op(0, 1, 0, 32'd100, 32'd7, "divu", -1);
    check_eq("tp_divu_lo", Lo, 32'd14);
    check_eq("tp_divu_hi", Hi, 32'd2);

    mt(1, 0, 32'h1234);
    mt(0, 1, 32'h5678);
    run_op(0, 1, 0, 32'd5, 32'd0, "divzero", -1);
    check_eq("tp_dz_hi", Hi, 32'h1234);
    check_eq("tp_dz_lo", Lo, 32'h5678);

    run_op(0, 1, 1, 32'h80000000, 32'hFFFFFFFF, "div_ovf", -1);
    check_eq("tp_ovf_lo", Lo, 32'h80000000);
    check_eq("tp_ovf_hi", Hi, 32'h0);
    run_op(1, 1, 0, 32'd6, 32'd0, "both_start", -1);
    run_op(1, 0, 1, 32'hFFFFFF00, 32'h00012345, "busy_ignore", 5);
    mt(1, 1, 32'hCAFEF00D);

    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rm = 1'($urandom);
      rs = 1'($urandom);
      run_op(rm, !rm, rs, ra, rb, "rand", -1);
    end

    // Reset in the middle of a multiply: aborted, no Done
    $display("start abort: mult a=%h b=%h", 32'd9, 32'd9);
    MultStart = 1'b1; IsSigned = 1'b0; A = 32'd9; B = 32'd9;
    @(posedge Clk); #1 MultStart = 1'b0;
    repeat (10) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge Clk);
    check_eq("abort_busy", Busy, 0);
    check_eq("abort_hi", Hi, 0);
    check_eq("abort_lo", Lo, 0);
    check_eq("abort_done", Done, 0);
    repeat (40) @(negedge Clk);

    run_op(0, 1, 1, 32'd77, 32'd0, "dz_after_rst", -1);
    repeat (5) @(negedge Clk);
    check_eq("done_count", 64'(done_seen), 64'(ops_pushed));
    check_eq("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
